// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline types and constants for the hazard unit
package pipe_pkg;

  // Hazard controller states
  typedef enum logic {
    HZ_RUN      = 1'b0,
    HZ_LU_STALL = 1'b1
  } hz_state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Bit positions inside the two-bit WB control field
  localparam int WB_MEMTOREG = 1;
  localparam int WB_REGWR    = 0;

  // True when a WB field describes a load that writes the register file
  function automatic logic wb_is_load(input logic [1:0] wb);
    return wb[WB_MEMTOREG] & wb[WB_REGWR];
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// rtl/hazard_ctrl_if.sv - pipeline-to-hazard-unit signal bundle
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();

  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_use_rs;
  logic             id_use_rt;
  logic             ex_memtoreg;
  logic             ex_regwr;
  logic [4:0]       ex_rt;
  logic             br_taken;
  logic             dmem_ready;
  logic             load_used;
  logic             pc_we;
  logic             if_id_we;
  logic             if_id_flush;
  logic             freeze;
  logic [CNT_W-1:0] bubble_cnt;

  // Pipeline side: supplies instruction fields, consumes stall/flush controls
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_memtoreg, ex_regwr, ex_rt,
           br_taken, dmem_ready,
    input  load_used, pc_we, if_id_we, if_id_flush, freeze, bubble_cnt
  );

  // Hazard controller side
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_memtoreg, ex_regwr, ex_rt,
           br_taken, dmem_ready,
    output load_used, pc_we, if_id_we, if_id_flush, freeze, bubble_cnt
  );

endinterface

// File: rtl/load_use_cmp.sv
// rtl/load_use_cmp.sv - combinational load-use dependency comparator
module load_use_cmp
  import pipe_pkg::*;
(
  input  logic [4:0] id_rs_i,
  input  logic [4:0] id_rt_i,
  input  logic       id_use_rs_i,
  input  logic       id_use_rt_i,
  input  logic       ex_memtoreg_i,
  input  logic       ex_regwr_i,
  input  logic [4:0] ex_rt_i,
  output logic       hit_o
);

  logic [1:0] ex_wb;
  logic       rs_dep;
  logic       rt_dep;

  // A load into $zero never produces a value, so it cannot cause a hazard
  always_comb begin
    ex_wb                = '0;
    ex_wb[WB_MEMTOREG]   = ex_memtoreg_i;
    ex_wb[WB_REGWR]      = ex_regwr_i;
    rs_dep = id_use_rs_i && (id_rs_i == ex_rt_i);
    rt_dep = id_use_rt_i && (id_rt_i == ex_rt_i);
    hit_o  = wb_is_load(ex_wb) && (ex_rt_i != REG_ZERO) && (rs_dep || rt_dep);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - load-use stall, branch flush and memory freeze control
module hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned CNT_W             = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL_CYCLES - 1);

  hz_state_e        state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic             br_pend_q, br_pend_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  logic hit;
  logic br_eff;
  logic load_used, pc_we, if_id_we, if_id_flush, freeze;

  load_use_cmp u_cmp (
    .id_rs_i       (hz.id_rs),
    .id_rt_i       (hz.id_rt),
    .id_use_rs_i   (hz.id_use_rs),
    .id_use_rt_i   (hz.id_use_rt),
    .ex_memtoreg_i (hz.ex_memtoreg),
    .ex_regwr_i    (hz.ex_regwr),
    .ex_rt_i       (hz.ex_rt),
    .hit_o         (hit)
  );

  // A branch seen during a freeze is remembered and applied once memory is ready
  assign br_eff = hz.br_taken | br_pend_q;

  // Next state and per-cycle controls, in strict priority order
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    br_pend_d   = br_pend_q;
    load_used   = 1'b0;
    pc_we       = 1'b1;
    if_id_we    = 1'b1;
    if_id_flush = 1'b0;
    freeze      = 1'b0;
    if (rst) begin
      load_used   = 1'b1;
      if_id_flush = 1'b1;
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      state_d     = HZ_RUN;
      cnt_d       = '0;
      br_pend_d   = 1'b0;
    end else if (!hz.dmem_ready) begin
      freeze   = 1'b1;
      pc_we    = 1'b0;
      if_id_we = 1'b0;
      if (hz.br_taken) br_pend_d = 1'b1;
    end else if (br_eff) begin
      // Squashes the stalled instruction, so any pending bubbles are dropped
      if_id_flush = 1'b1;
      load_used   = 1'b1;
      state_d     = HZ_RUN;
      cnt_d       = '0;
      br_pend_d   = 1'b0;
    end else if (state_q == HZ_LU_STALL) begin
      load_used = 1'b1;
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      cnt_d     = cnt_q - 3'd1;
      if (cnt_q == 3'd1) state_d = HZ_RUN;
    end else if (hit) begin
      load_used = 1'b1;
      pc_we     = 1'b0;
      if_id_we  = 1'b0;
      if (LOAD_STALL_CYCLES > 1) begin
        state_d = HZ_LU_STALL;
        cnt_d   = STALL_INIT;
      end
    end
  end

  // Saturating count of bubble cycles
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (rst) begin
      bubble_cnt_d = '0;
    end else if (load_used && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // State register on the falling edge, in step with the pipeline registers
  always_ff @(negedge clk) begin
    if (rst) begin
      state_q      <= HZ_RUN;
      cnt_q        <= '0;
      br_pend_q    <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      br_pend_q    <= br_pend_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign hz.load_used   = load_used;
  assign hz.pc_we       = pc_we;
  assign hz.if_id_we    = if_id_we;
  assign hz.if_id_flush = if_id_flush;
  assign hz.freeze      = freeze;
  assign hz.bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl
module tb_hazard_ctrl;

  typedef struct {
    logic       rst;
    logic [4:0] id_rs, id_rt;
    logic       use_rs, use_rt, memtoreg, regwr;
    logic [4:0] ex_rt;
    logic       br, ready;
  } in_t;

  typedef struct {
    logic        lu, pc, ifid, fl, fz;
    logic [31:0] bc;
  } out_t;

  typedef struct {
    in_t        i;
    logic       lu, pc, ifid, fl, fz;
    logic [3:0] bc;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  hazard_ctrl_if #(.CNT_W(16)) if1 ();
  hazard_ctrl_if #(.CNT_W(4))  if3 ();

  hazard_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) u1 (.clk(clk), .rst(rst), .hz(if1.slave));
  hazard_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(4))  u3 (.clk(clk), .rst(rst), .hz(if3.slave));

  int checks   = 0;
  int failures = 0;

  // Reference model: remaining bubbles after this one, deferred branch, bubble total
  int          m_lsc [2] = '{1, 3};
  int unsigned m_max [2] = '{65535, 15};
  int          m_rem [2];
  bit          m_pend[2];
  int unsigned m_cnt [2];

  out_t g1, g3;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic in_t mk(logic r, logic [4:0] rs, logic [4:0] rt, logic urs, logic urt,
                             logic m2r, logic rw, logic [4:0] ert, logic br, logic rdy);
    in_t v;
    v.rst = r; v.id_rs = rs; v.id_rt = rt; v.use_rs = urs; v.use_rt = urt;
    v.memtoreg = m2r; v.regwr = rw; v.ex_rt = ert; v.br = br; v.ready = rdy;
    return v;
  endfunction

  function automatic bit hit_of(in_t v);
    return v.memtoreg && v.regwr && (v.ex_rt != 0) &&
           ((v.use_rs && v.id_rs == v.ex_rt) || (v.use_rt && v.id_rt == v.ex_rt));
  endfunction

  function automatic out_t model_eval(int k, in_t v);
    out_t o;
    o.lu = 0; o.pc = 1; o.ifid = 1; o.fl = 0; o.fz = 0; o.bc = m_cnt[k];
    if (v.rst) begin
      o.lu = 1; o.fl = 1; o.pc = 0; o.ifid = 0;
    end else if (!v.ready) begin
      o.fz = 1; o.pc = 0; o.ifid = 0;
    end else if (v.br || m_pend[k]) begin
      o.fl = 1; o.lu = 1;
    end else if (m_rem[k] > 0 || hit_of(v)) begin
      o.lu = 1; o.pc = 0; o.ifid = 0;
    end
    return o;
  endfunction

  task automatic model_upd(int k, in_t v, out_t o);
    if (v.rst) begin
      m_rem[k] = 0; m_pend[k] = 0; m_cnt[k] = 0;
    end else begin
      if (o.lu && m_cnt[k] < m_max[k]) m_cnt[k]++;
      if (!v.ready) begin
        if (v.br) m_pend[k] = 1;
      end else if (v.br || m_pend[k]) begin
        m_rem[k] = 0; m_pend[k] = 0;
      end else if (m_rem[k] > 0) begin
        m_rem[k]--;
      end else if (hit_of(v)) begin
        m_rem[k] = m_lsc[k] - 1;
      end
    end
  endtask

  task automatic drive(in_t v);
    rst = v.rst;
    if1.id_rs = v.id_rs; if1.id_rt = v.id_rt; if1.id_use_rs = v.use_rs; if1.id_use_rt = v.use_rt;
    if1.ex_memtoreg = v.memtoreg; if1.ex_regwr = v.regwr; if1.ex_rt = v.ex_rt;
    if1.br_taken = v.br; if1.dmem_ready = v.ready;
    if3.id_rs = v.id_rs; if3.id_rt = v.id_rt; if3.id_use_rs = v.use_rs; if3.id_use_rt = v.use_rt;
    if3.ex_memtoreg = v.memtoreg; if3.ex_regwr = v.regwr; if3.ex_rt = v.ex_rt;
    if3.br_taken = v.br; if3.dmem_ready = v.ready;
  endtask

  task automatic cmp_all(string tag, out_t g, out_t e);
    check({tag, " load_used"},   32'(g.lu),   32'(e.lu));
    check({tag, " pc_we"},       32'(g.pc),   32'(e.pc));
    check({tag, " if_id_we"},    32'(g.ifid), 32'(e.ifid));
    check({tag, " if_id_flush"}, 32'(g.fl),   32'(e.fl));
    check({tag, " freeze"},      32'(g.fz),   32'(e.fz));
    check({tag, " bubble_cnt"},  g.bc,        e.bc);
  endtask

  // One pipeline cycle: drive after the falling edge, sample mid-cycle, advance model at the edge
  task automatic step(in_t v);
    out_t e1, e3;
    drive(v);
    @(posedge clk);
    e1 = model_eval(0, v);
    e3 = model_eval(1, v);
    g1.lu = if1.load_used; g1.pc = if1.pc_we; g1.ifid = if1.if_id_we;
    g1.fl = if1.if_id_flush; g1.fz = if1.freeze; g1.bc = 32'(if1.bubble_cnt);
    g3.lu = if3.load_used; g3.pc = if3.pc_we; g3.ifid = if3.if_id_we;
    g3.fl = if3.if_id_flush; g3.fz = if3.freeze; g3.bc = 32'(if3.bubble_cnt);
    cmp_all("model u1", g1, e1);
    cmp_all("model u3", g3, e3);
    @(negedge clk);
    model_upd(0, v, e1);
    model_upd(1, v, e3);
    #1;
  endtask

  function automatic void add(in_t i, logic lu, logic pc, logic ifid, logic fl, logic fz, logic [3:0] bc);
    vec_t t;
    t.i = i; t.lu = lu; t.pc = pc; t.ifid = ifid; t.fl = fl; t.fz = fz; t.bc = bc;
    tbl.push_back(t);
  endfunction

  initial begin
    in_t idle, ld5, v;
    idle = mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 1);
    ld5  = mk(0, 5'd5, 5'd2, 1, 0, 1, 1, 5'd5, 0, 1);

    // Expectations for the LOAD_STALL_CYCLES=3 / 4-bit counter instance
    add(mk(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 1), 1, 0, 0, 1, 0, 0);
    add(idle, 0, 1, 1, 0, 0, 0);
    add(ld5,  1, 0, 0, 0, 0, 0);
    add(idle, 1, 0, 0, 0, 0, 1);
    add(ld5,  1, 0, 0, 0, 0, 2);
    add(idle, 0, 1, 1, 0, 0, 3);
    add(mk(0, 5'd0, 5'd2, 1, 0, 1, 1, 5'd0, 0, 1), 0, 1, 1, 0, 0, 3);
    add(mk(0, 5'd5, 5'd2, 0, 0, 1, 1, 5'd5, 0, 1), 0, 1, 1, 0, 0, 3);
    add(mk(0, 5'd1, 5'd7, 0, 1, 1, 1, 5'd7, 0, 1), 1, 0, 0, 0, 0, 3);
    add(mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 1, 1), 1, 1, 1, 1, 0, 4);
    add(idle, 0, 1, 1, 0, 0, 5);
    add(ld5,  1, 0, 0, 0, 0, 5);
    for (int i = 0; i < 4; i++) add(mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0), 0, 0, 0, 0, 1, 6);
    add(idle, 1, 0, 0, 0, 0, 6);
    add(idle, 1, 0, 0, 0, 0, 7);
    add(idle, 0, 1, 1, 0, 0, 8);
    add(mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 1, 0), 0, 0, 0, 0, 1, 8);
    add(mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 0), 0, 0, 0, 0, 1, 8);
    add(idle, 1, 1, 1, 1, 0, 8);
    add(idle, 0, 1, 1, 0, 0, 9);
    add(ld5,  1, 0, 0, 0, 0, 9);
    add(mk(1, 5'd5, 5'd2, 1, 0, 1, 1, 5'd5, 0, 1), 1, 0, 0, 1, 0, 10);
    add(idle, 0, 1, 1, 0, 0, 0);
    add(mk(0, 5'd5, 5'd2, 1, 0, 1, 1, 5'd5, 1, 1), 1, 1, 1, 1, 0, 0);
    add(idle, 0, 1, 1, 0, 0, 1);
    add(mk(0, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 1, 0), 0, 0, 0, 0, 1, 1);
    add(mk(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 1), 1, 0, 0, 1, 0, 1);
    add(idle, 0, 1, 1, 0, 0, 0);

    // Initial reset edge before any comparison
    drive(mk(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 1));
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin m_rem[k] = 0; m_pend[k] = 0; m_cnt[k] = 0; end
    #1;

    foreach (tbl[i]) begin
      step(tbl[i].i);
      check($sformatf("tbl[%0d] load_used", i),   32'(g3.lu),   32'(tbl[i].lu));
      check($sformatf("tbl[%0d] pc_we", i),       32'(g3.pc),   32'(tbl[i].pc));
      check($sformatf("tbl[%0d] if_id_we", i),    32'(g3.ifid), 32'(tbl[i].ifid));
      check($sformatf("tbl[%0d] if_id_flush", i), 32'(g3.fl),   32'(tbl[i].fl));
      check($sformatf("tbl[%0d] freeze", i),      32'(g3.fz),   32'(tbl[i].fz));
      check($sformatf("tbl[%0d] bubble_cnt", i),  g3.bc,        32'(tbl[i].bc));
    end

    // Single-bubble instance: one stall cycle, then normal flow
    step(mk(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 1));
    step(ld5);
    check("u1 bubble load_used", 32'(g1.lu), 32'd1);
    check("u1 bubble pc_we", 32'(g1.pc), 32'd0);
    step(idle);
    check("u1 after load_used", 32'(g1.lu), 32'd0);
    check("u1 after pc_we", 32'(g1.pc), 32'd1);
    check("u1 after bubble_cnt", g1.bc, 32'd1);

    // Saturation: 2^4+5 back-to-back bubbles on the 4-bit counter
    step(mk(1, 5'd1, 5'd2, 0, 0, 0, 0, 5'd0, 0, 1));
    for (int i = 0; i < 21; i++) step(ld5);
    step(idle);
    check("u3 saturated bubble_cnt", g3.bc, 32'd15);
    check("u1 21 bubbles bubble_cnt", g1.bc, 32'd21);
    check("u3 after saturation pc_we", 32'(g3.pc), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      v.rst      = ($urandom_range(63) == 0);
      v.id_rs    = 5'($urandom_range(3));
      v.id_rt    = 5'($urandom_range(3));
      v.use_rs   = 1'($urandom_range(1));
      v.use_rt   = 1'($urandom_range(1));
      v.memtoreg = ($urandom_range(3) != 0);
      v.regwr    = ($urandom_range(7) != 0);
      v.ex_rt    = 5'($urandom_range(3));
      v.br       = ($urandom_range(9) == 0);
      v.ready    = ($urandom_range(4) != 0);
      step(v);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
